// File: rtl/mprj_serial_pkg.sv
// Shared types and helpers for the GPIO serial configuration loader.
// Holds the FSM state enum, serial phase encoding and sizing functions.
package mprj_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } state_e;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Pads per chain, rounded up so every pad has a slot.
    function automatic int calc_ppc(input int pads, input int chains);
        return (pads + chains - 1) / chains;
    endfunction

    function automatic int calc_aw(input int pads);
        return (pads > 1) ? $clog2(pads) : 1;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mprj_serial_clkgen.sv
// Serial clock divider: counts div+1 cycles per phase and toggles the phase.
// Ports: clk, resetn, en (sync clear when low), div -> phase_end, sclk level.
module mprj_serial_clkgen
    import mprj_serial_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             phase_end,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;

    // The count wraps at div, so div = all-ones never overflows.
    assign phase_end = en && (cnt_q == div);
    assign sclk      = (phase_q == PH_HIGH);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = PH_LOW;
        end else if (phase_end) begin
            cnt_d   = '0;
            phase_d = (phase_q == PH_LOW) ? PH_HIGH : PH_LOW;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= PH_LOW;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mprj_serial_loader.sv
// Fetches per-pad control words and shifts them out over parallel chains.
// Ports: start/abort/clk_div control, cfg_rd_* fetch, busy/done/aborted, serial_*.
module mprj_serial_loader
    import mprj_serial_pkg::*;
#(
    parameter  int IO_PADS   = 38,
    parameter  int CHAINS    = 2,
    parameter  int CTRL_BITS = 13,
    parameter  int CLK_DIV_W = 8,
    localparam int PPC       = calc_ppc(IO_PADS, CHAINS),
    localparam int AW        = calc_aw(IO_PADS)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CLK_DIV_W-1:0]        clk_div,
    output logic                        cfg_rd_en,
    output logic [CHAINS*AW-1:0]        cfg_rd_addr,
    input  logic [CHAINS*CTRL_BITS-1:0] cfg_rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic                        serial_clock,
    output logic                        serial_resetn,
    output logic                        serial_load,
    output logic [CHAINS-1:0]           serial_data_out
);

    localparam int SW = cnt_w(PPC);
    localparam int BW = cnt_w(CTRL_BITS);

    state_e                             state_q, state_d;
    logic [SW-1:0]                      slot_q, slot_d;
    logic [BW-1:0]                      bit_q, bit_d;
    logic [CLK_DIV_W-1:0]               div_q, div_d;
    logic [CHAINS-1:0][CTRL_BITS-1:0]   stage_q, stage_d;
    logic                               rd_en_q, rd_en_d;
    logic [CHAINS*AW-1:0]               addr_q, addr_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               srst_q;
    logic                               kill;
    logic                               gen_en;
    logic                               phase_end;
    logic                               sclk_lvl;
    logic                               bit_end;

    function automatic logic phantom(input int c, input logic [SW-1:0] s);
        return (c * PPC + int'(s)) >= IO_PADS;
    endfunction

    // Phantom slots keep address 0; their data is masked on capture.
    function automatic logic [CHAINS*AW-1:0] pad_addr(input logic [SW-1:0] s);
        logic [CHAINS*AW-1:0] a;
        a = '0;
        for (int c = 0; c < CHAINS; c++) begin
            if (!phantom(c, s)) begin
                a[c*AW +: AW] = AW'(c * PPC + int'(s));
            end
        end
        return a;
    endfunction

    assign kill    = abort && (state_q != ST_IDLE);
    assign gen_en  = ((state_q == ST_SHIFT) || (state_q == ST_LOAD)) && !kill;
    assign bit_end = phase_end && sclk_lvl;

    mprj_serial_clkgen #(
        .DIV_W (CLK_DIV_W)
    ) u_clkgen (
        .clk       (clk),
        .resetn    (resetn),
        .en        (gen_en),
        .div       (div_q),
        .phase_end (phase_end),
        .sclk      (sclk_lvl)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        div_d   = div_q;
        stage_d = stage_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort && !busy_q) begin
                    div_d   = clk_div;
                    slot_d  = SW'(PPC - 1);
                    rd_en_d = 1'b1;
                    addr_d  = pad_addr(SW'(PPC - 1));
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                for (int c = 0; c < CHAINS; c++) begin
                    stage_d[c] = phantom(c, slot_q) ? '0
                               : cfg_rd_data[c*CTRL_BITS +: CTRL_BITS];
                end
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    if (bit_q == BW'(CTRL_BITS - 1)) begin
                        if (slot_q != '0) begin
                            slot_d  = slot_q - SW'(1);
                            rd_en_d = 1'b1;
                            addr_d  = pad_addr(slot_q - SW'(1));
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        for (int c = 0; c < CHAINS; c++) begin
                            stage_d[c] = {stage_q[c][CTRL_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (bit_end) begin
                    stage_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
            stage_d = '0;
            rd_en_d = 1'b0;
            done_d  = 1'b0;
        end
        // Held through the done cycle so busy drops one cycle later.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            stage_q <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            stage_q <= stage_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            srst_q  <= 1'b1;
        end
    end

    always_comb begin
        serial_data_out = '0;
        for (int c = 0; c < CHAINS; c++) begin
            serial_data_out[c] = stage_q[c][CTRL_BITS-1];
        end
    end

    // The divider keeps running through LOAD to time the strobe,
    // so its level only reaches the chain during SHIFT.
    assign serial_clock  = sclk_lvl && (state_q == ST_SHIFT);
    assign serial_load   = (state_q == ST_LOAD) && !sclk_lvl;
    assign serial_resetn = srst_q;
    assign cfg_rd_en     = rd_en_q;
    assign cfg_rd_addr   = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = kill;

endmodule

// File: tb/tb_mprj_serial_loader.sv
// Directed/random bench for mprj_serial_loader with a word-level model.
// Instance 0 uses 38 pads, instance 1 uses 37 pads (phantom slot).
module tb_mprj_serial_loader;

    localparam int NB  = 13;
    localparam int PPC = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [1:0]  start, abort, rd_en, busy, done, aborted;
    logic [1:0]  sclk, srstn, sload;
    logic [7:0]  clk_div;
    logic [11:0] rd_addr [2];
    logic [25:0] rd_data [2];
    logic [1:0]  sdo [2];
    logic [12:0] regfile [38];
    bit          cap [4][$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit prev_s, had_hi, load_seen, done_seen;
    int run, hi_min, hi_max, lo_min, lrun, load_len, load_pulses;

    mprj_serial_loader #(
        .IO_PADS(38), .CHAINS(2), .CTRL_BITS(13), .CLK_DIV_W(8)
    ) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort[0]),
        .clk_div(clk_div), .cfg_rd_en(rd_en[0]), .cfg_rd_addr(rd_addr[0]),
        .cfg_rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]),
        .aborted(aborted[0]), .serial_clock(sclk[0]),
        .serial_resetn(srstn[0]), .serial_load(sload[0]),
        .serial_data_out(sdo[0])
    );

    mprj_serial_loader #(
        .IO_PADS(37), .CHAINS(2), .CTRL_BITS(13), .CLK_DIV_W(8)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort[1]),
        .clk_div(clk_div), .cfg_rd_en(rd_en[1]), .cfg_rd_addr(rd_addr[1]),
        .cfg_rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]),
        .aborted(aborted[1]), .serial_clock(sclk[1]),
        .serial_resetn(srstn[1]), .serial_load(sload[1]),
        .serial_data_out(sdo[1])
    );

    always @(posedge clk) cyc++;

    for (genvar i = 0; i < 2; i++) begin : g_inst
        always @(posedge clk) begin
            if (rd_en[i]) begin
                for (int c = 0; c < 2; c++) begin
                    int a;
                    a = int'(rd_addr[i][c*6 +: 6]);
                    rd_data[i][c*13 +: 13] <= (a < 38) ? regfile[a] : 13'h1fff;
                end
            end
        end
        always @(posedge sclk[i]) begin
            cap[2*i].push_back(sdo[i][0]);
            cap[2*i+1].push_back(sdo[i][1]);
        end
    end

    always @(negedge clk) begin
        if (sclk[0] === prev_s) begin
            run++;
        end else begin
            if (prev_s) begin
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
            end else if (had_hi) begin
                if (run < lo_min) lo_min = run;
            end
            had_hi = had_hi || prev_s;
            prev_s = sclk[0];
            run = 1;
        end
        if (sload[0] === 1'b1) begin
            lrun++;
            load_seen = 1'b1;
        end else if (lrun != 0) begin
            load_len = lrun;
            load_pulses++;
            lrun = 0;
        end
        if (done[0] === 1'b1) done_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        prev_s = sclk[0];
        had_hi = 1'b0;
        run = 0;
        hi_min = 99999;
        hi_max = 0;
        lo_min = 99999;
        lrun = 0;
        load_len = 0;
        load_pulses = 0;
        load_seen = 1'b0;
        done_seen = 1'b0;
    endtask

    task automatic fill_random();
        for (int p = 0; p < 38; p++) regfile[p] = 13'($urandom);
    endtask

    function automatic logic [12:0] exp_word(input int pads, input int c,
                                             input int s);
        int pad;
        pad = c * PPC + s;
        return (pad < pads) ? regfile[pad] : 13'h0;
    endfunction

    task automatic run_xfer(input int i, input int d, input bit mid_start);
        int t0, got, expc, pads;
        logic [12:0] w;
        for (int q = 0; q < 4; q++) cap[q].delete();
        @(negedge clk);
        #1;
        mon_clear();
        clk_div = 8'(d);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        t0 = cyc;
        check($sformatf("rd_en_latency_i%0d", i), 32'(rd_en[i]), 1);
        check($sformatf("busy_rise_i%0d", i), 32'(busy[i]), 1);
        check($sformatf("first_addr_i%0d", i), 32'(rd_addr[i][5:0]), 18);
        got = -1;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            start[i] = mid_start && (n == 150);
            if (done[i] === 1'b1) begin
                got = cyc - t0;
                break;
            end
        end
        start[i] = 1'b0;
        expc = PPC * (2 + NB * 2 * (d + 1)) + 2 * (d + 1) + 1;
        check($sformatf("done_latency_i%0d_d%0d", i, d), got, expc);
        check($sformatf("busy_at_done_i%0d", i), 32'(busy[i]), 1);
        @(negedge clk);
        check($sformatf("busy_fall_i%0d", i), 32'(busy[i]), 0);
        check($sformatf("done_one_cycle_i%0d", i), 32'(done[i]), 0);
        pads = (i == 0) ? 38 : 37;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("bit_count_i%0d_c%0d", i, c),
                  cap[2*i+c].size(), PPC * NB);
            if (cap[2*i+c].size() >= PPC * NB) begin
                for (int k = 0; k < PPC; k++) begin
                    w = '0;
                    for (int j = 0; j < NB; j++) begin
                        w = {w[11:0], cap[2*i+c][k*NB+j]};
                    end
                    check($sformatf("word_i%0d_c%0d_s%0d", i, c, PPC-1-k),
                          32'(w), 32'(exp_word(pads, c, PPC-1-k)));
                end
            end
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        start = '0;
        abort = '0;
        clk_div = '0;
        fill_random();
        #23;
        check("rst_ctrl", {30'd0, busy[0], done[0]}, 0);
        check("rst_rd", {30'd0, aborted[0], rd_en[0]}, 0);
        check("rst_serial", {28'd0, sclk[0], sload[0], sdo[0]}, 0);
        check("rst_srstn", 32'(srstn[0]), 0);
        check("rst_addr", 32'(rd_addr[0]), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("srstn_release", 32'(srstn[0]), 1);

        // Full transfer with the constant 1100000000001 pattern.
        for (int p = 0; p < 38; p++) regfile[p] = 13'h1801;
        run_xfer(0, 0, 1'b0);

        // Divider D=3, random data, and a start pulse while busy.
        fill_random();
        run_xfer(0, 3, 1'b1);
        check("sclk_high_min", hi_min, 4);
        check("sclk_high_max", hi_max, 4);
        check("sclk_low_min", lo_min, 4);
        check("load_width", load_len, 4);
        check("load_pulses", load_pulses, 1);

        // 37 pads: chain 1 slot 18 is a phantom pad.
        fill_random();
        run_xfer(1, 0, 1'b0);

        // Abort at bit 5 of the third pad.
        for (int q = 0; q < 4; q++) cap[q].delete();
        @(negedge clk);
        #1;
        mon_clear();
        clk_div = 8'd1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (cap[0].size() < 32 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", cap[0].size(), 32);
        #1;
        abort[0] = 1'b1;
        #1;
        check("aborted_same_cycle", 32'(aborted[0]), 1);
        @(negedge clk);
        abort[0] = 1'b0;
        check("aborted_one_cycle", 32'(aborted[0]), 0);
        check("abort_sclk", 32'(sclk[0]), 0);
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_sdo", 32'(sdo[0]), 0);
        repeat (40) @(negedge clk);
        check("abort_no_load", 32'(load_seen), 0);
        check("abort_no_done", 32'(done_seen), 0);

        // start and abort together in IDLE.
        #1;
        start[0] = 1'b1;
        abort[0] = 1'b1;
        #1;
        check("idle_abort_no_pulse", 32'(aborted[0]), 0);
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("idle_abort_busy", 32'(busy[0]), 0);
        check("idle_abort_rd_en", 32'(rd_en[0]), 0);
        repeat (3) @(negedge clk);
        check("idle_abort_busy_later", 32'(busy[0]), 0);

        // Maximum divider: phases of 256 cycles.
        #1;
        clk_div = 8'hff;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (sclk[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (sclk[0] === 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
        end
        check("div_max_high", n, 256);
        n = 0;
        while (sclk[0] === 1'b0 && n < 600) begin
            n++;
            @(negedge clk);
        end
        check("div_max_low", n, 256);
        #1;
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("div_max_abort_busy", 32'(busy[0]), 0);

        // Asynchronous reset in the middle of SHIFT.
        for (int q = 0; q < 4; q++) cap[q].delete();
        #1;
        clk_div = 8'd2;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!(cap[0].size() >= 10 && sclk[0] === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach", 32'(sclk[0]), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_srstn", 32'(srstn[0]), 0);
        check("rst_mid_sclk", 32'(sclk[0]), 0);
        check("rst_mid_busy", 32'(busy[0]), 0);
        check("rst_mid_rd_en", 32'(rd_en[0]), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_srstn_back", 32'(srstn[0]), 1);
        fill_random();
        run_xfer(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
